ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the key_count press counter.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port clrn  input  1  reset; asynchronous, active-high (clrn=1 resets).
REQ-004 SHALL have port ready  input  1  PS/2 receiver FIFO holds at least one byte.
REQ-005 SHALL have port data  input  8  PS/2 receiver FIFO head byte; valid while ready=1.
REQ-006 SHALL have port overflow  input  1  PS/2 receiver FIFO overflow indication.
REQ-007 SHALL have port nextdata_n  output  1  active-low pop strobe to the receiver; one cycle wide.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse; a decoded key event is on key_* outputs.
REQ-009 SHALL have port key_code  output  8  scan code of the event; held until the next event.
REQ-010 SHALL have port key_make  output  1  1 = press, 0 = release, for the current event.
REQ-011 SHALL have port key_ext  output  1  event was prefixed by E0.
REQ-012 SHALL have port key_rpt  output  1  event is a typematic repeat of the held key.
REQ-013 SHALL have port key_count  output  CNT_W  number of new (non-repeat) presses.
REQ-014 SHALL have port shift_flag, ctrl_flag, caps_flag  output  1 each  modifier state.
REQ-015 SHALL have port disp_en  output  1  a non-modifier key is currently held.
REQ-016 SHALL have port err  output  1  sticky; overflow was seen since reset.

Function
REQ-017 SHALL implement states IDLE and ACK; IDLE->ACK when ready=1, ACK->IDLE unconditionally; no other transitions.
REQ-018 SHALL capture data at the edge leaving IDLE; nextdata_n SHALL be 0 exactly during the ACK cycle, 1 otherwise (registered output).
REQ-019 SHALL ignore ready in ACK; back-to-back bytes therefore pop at most once per 2 cycles.
REQ-020 SHALL, for captured byte F0, set break-pending; for E0, set ext-pending; neither produces key_valid.
REQ-021 SHALL, for any other byte, pulse key_valid in the ACK cycle with key_code=byte, key_make=!break-pending, key_ext=ext-pending, then clear both pendings.
REQ-022 SHALL track held code (code plus ext): make equal to held code -> key_rpt=1, no count; make of different non-modifier code -> held=new code, key_count+1, key_rpt=0.
REQ-023 SHALL clear held state on break matching held code; break of non-held code changes nothing but still emits key_valid.
REQ-024 SHALL set shift_flag on make of 12 or 59, clear on break of either; ctrl_flag likewise for 14 (with or without E0).
REQ-025 SHALL toggle caps_flag on make of 58 only when not a repeat; break of 58 no effect.
REQ-026 SHALL not count modifier makes (12, 59, 14, 58) nor alter held state with them.
REQ-027 SHALL wrap key_count from 2^CNT_W-1 to 0 without saturation.
REQ-028 SHALL drive disp_en = held state valid.
REQ-029 SHALL, when overflow=1 on any edge, set err, clear both pendings, and suppress key_valid for a byte captured that same edge; FSM sequencing continues.
REQ-030 SHALL give F0 then E0 (either order) the same result as E0 then F0.

Reset
REQ-031 SHALL, on clrn=1, immediately force IDLE, nextdata_n=1, key_valid=0, key_code=00, key_make=0, key_ext=0, key_rpt=0, key_count=0, all flags 0, disp_en=0, err=0, pendings and held state cleared, including mid-ACK.

Verification
REQ-032 SHALL cover: bytes 1C, F0, 1C -> key_valid x2, first key_code=1C key_make=1 key_count=1 disp_en=1, second key_make=0 disp_en=0.
REQ-033 SHALL cover: 1C,1C,1C,F0,1C -> three makes with key_rpt=0,1,1, key_count=1.
REQ-034 SHALL cover: 58, F0,58, 58, F0,58 -> caps_flag 1 then 0; key_count unchanged; 12 then F0,12 -> shift_flag 1 then 0.
REQ-035 SHALL cover: E0,75,E0,F0,75 -> key_ext=1 both events, make then break; ready held high -> nextdata_n low every second cycle exactly once per byte.
REQ-036 SHALL cover: key_count=FF, new key 1C -> key_count=00; overflow=1 pulse -> err=1 persisting until clrn.
REQ-037 SHALL cover: clrn asserted during ACK after F0 -> nextdata_n=1 same cycle, next byte 1C decoded as make.

Source files
------------

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns PS/2 scan-code bytes into make/break key events and tracks the modifier keys.
// Latency: the byte is captured on the IDLE->ACK edge, and key_valid/key_* are presented during that ACK cycle.
// Backpressure: at most one byte is popped every two cycles; ready is ignored while in ACK.
module ps2_key_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_make,
  output logic             key_ext,
  output logic             key_rpt,
  output logic [CNT_W-1:0] key_count,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic             caps_flag,
  output logic             disp_en,
  output logic             err
);

  localparam logic [7:0] BRK_CODE  = 8'hF0;
  localparam logic [7:0] EXT_CODE  = 8'hE0;
  localparam logic [7:0] LSHIFT    = 8'h12;
  localparam logic [7:0] RSHIFT    = 8'h59;
  localparam logic [7:0] CTRL_CODE = 8'h14;
  localparam logic [7:0] CAPS_CODE = 8'h58;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t     state, state_nxt;
  logic       brk_pend, ext_pend;
  logic       held_vld, held_ext;
  logic [7:0] held_code;

  logic capture, is_brk, is_ext, is_shift, is_mod, held_match, event_ok;

  // A byte is taken from the receiver only when idle; the next cycle is the pop (ACK) cycle.
  assign capture    = (state == IDLE) && ready;
  assign is_brk     = (data == BRK_CODE);
  assign is_ext     = (data == EXT_CODE);
  assign is_shift   = (data == LSHIFT) || (data == RSHIFT);
  assign is_mod     = is_shift || (data == CTRL_CODE) || (data == CAPS_CODE);
  // The held key is identified by code plus its E0 prefix.
  assign held_match = held_vld && (held_code == data) && (held_ext == ext_pend);
  // Prefix bytes and bytes that arrive together with an overflow produce no event.
  assign event_ok   = capture && !overflow && !is_brk && !is_ext;
  assign disp_en    = held_vld;

  // State register.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: every accepted byte is followed by exactly one ACK cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered pop strobe, low for the whole ACK cycle.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) nextdata_n <= 1'b1;
    else      nextdata_n <= !capture;
  end

  // Prefix tracking and the sticky error; overflow discards any partial prefix.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      err      <= 1'b0;
    end else if (overflow) begin
      err      <= 1'b1;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
    end else if (capture) begin
      if (is_brk) begin
        brk_pend <= 1'b1;
      end else if (is_ext) begin
        ext_pend <= 1'b1;
      end else begin
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
      end
    end
  end

  // Key event decode, held-key tracking, press counter and modifier flags.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_make   <= 1'b0;
      key_ext    <= 1'b0;
      key_rpt    <= 1'b0;
      key_count  <= '0;
      shift_flag <= 1'b0;
      ctrl_flag  <= 1'b0;
      caps_flag  <= 1'b0;
      held_vld   <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else begin
      key_valid <= 1'b0;
      if (event_ok) begin
        key_valid <= 1'b1;
        key_code  <= data;
        key_make  <= !brk_pend;
        key_ext   <= ext_pend;
        key_rpt   <= !brk_pend && held_match;
        if (!brk_pend) begin
          // Modifiers never become the held key, so they are never seen as repeats.
          if (is_shift) begin
            shift_flag <= 1'b1;
          end else if (data == CTRL_CODE) begin
            ctrl_flag <= 1'b1;
          end else if (data == CAPS_CODE) begin
            if (!held_match) caps_flag <= !caps_flag;
          end else if (!held_match) begin
            held_vld  <= 1'b1;
            held_ext  <= ext_pend;
            held_code <= data;
            key_count <= key_count + 1'b1;
          end
        end else begin
          if (is_shift)             shift_flag <= 1'b0;
          if (data == CTRL_CODE)    ctrl_flag  <= 1'b0;
          if (held_match && !is_mod) held_vld  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomised and directed bench for ps2_key_ctrl with a queue-based receiver FIFO model.
// Expected key events come from a behavioural model and are checked by a separate monitor.
// The bench never stalls: every wait on the DUT is bounded.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       clrn, ready, overflow;
  logic [7:0] data;
  logic       nextdata_n, key_valid, key_make, key_ext, key_rpt;
  logic [7:0] key_code, key_count;
  logic       shift_flag, ctrl_flag, caps_flag, disp_en, err;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_make(key_make), .key_ext(key_ext), .key_rpt(key_rpt), .key_count(key_count),
    .shift_flag(shift_flag), .ctrl_flag(ctrl_flag), .caps_flag(caps_flag),
    .disp_en(disp_en), .err(err)
  );

  typedef struct packed {
    logic [7:0] code;
    logic       make, ext, rpt;
    logic [7:0] cnt;
    logic       shift, ctrl, caps, disp;
  } ev_t;

  logic [7:0] fifo_q[$];
  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ev_num = 0;

  // Behavioural model state: held key as (ext*256 + code), -1 when nothing held.
  bit m_brk, m_ext, m_shift, m_ctrl, m_caps;
  int m_held, m_cnt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_ctrl = 0; m_caps = 0;
    m_held = -1; m_cnt = 0;
  endtask

  task automatic model_ovf();
    m_brk = 0; m_ext = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    int  key;
    bit  mk, rpt;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      mk  = !m_brk;
      key = int'(m_ext) * 256 + int'(b);
      rpt = mk && (key == m_held);
      if (mk) begin
        if (b == 8'h12 || b == 8'h59) m_shift = 1;
        else if (b == 8'h14) m_ctrl = 1;
        else if (b == 8'h58) begin
          if (!rpt) m_caps = !m_caps;
        end else if (!rpt) begin
          m_held = key;
          m_cnt  = (m_cnt + 1) % 256;
        end
      end else begin
        if (b == 8'h12 || b == 8'h59) m_shift = 0;
        if (b == 8'h14) m_ctrl = 0;
        if (key == m_held) m_held = -1;
      end
      e.code = b; e.make = mk; e.ext = m_ext; e.rpt = rpt;
      e.cnt = m_cnt[7:0]; e.shift = m_shift; e.ctrl = m_ctrl; e.caps = m_caps;
      e.disp = (m_held != -1);
      exp_q.push_back(e);
      m_brk = 0; m_ext = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    fifo_q.push_back(b);
  endtask

  // Wait until the receiver FIFO has been emptied and the last ACK is over.
  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || nextdata_n == 1'b0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 3000), 32'd0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Receiver FIFO model: pop on the pop strobe, then present the new head.
  always @(negedge clk) begin
    if (nextdata_n == 1'b0) begin
      checks++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      else begin
        errors++;
        $display("FAIL pop_empty: got pop strobe, required no pop (FIFO empty)");
      end
    end
    ready = (fifo_q.size() > 0);
    data  = ready ? fifo_q[0] : 8'h00;
  end

  // Monitor: every key_valid pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (clrn == 1'b0 && key_valid == 1'b1) begin
      ev_t g;
      ev_t e;
      ev_num++;
      g = {key_code, key_make, key_ext, key_rpt, key_count, shift_flag, ctrl_flag, caps_flag, disp_en};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got event %h, required none", g);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("event%0d", ev_num), 32'(g), 32'(e));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] pick [10] = '{8'h1C, 8'h1B, 8'h23, 8'h75, 8'h12, 8'h59, 8'h14, 8'h58, 8'hF0, 8'hE0};

  initial begin
    int n;
    clrn = 1'b1; ready = 1'b0; data = 8'h00; overflow = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("rst_key_valid",  32'(key_valid),  32'd0);
    chk("rst_key_code",   32'(key_code),   32'd0);
    chk("rst_key_count",  32'(key_count),  32'd0);
    chk("rst_key_bits",   32'({key_make, key_ext, key_rpt}), 32'd0);
    chk("rst_flags",      32'({shift_flag, ctrl_flag, caps_flag, disp_en, err}), 32'd0);
    clrn = 1'b0;
    @(posedge clk); #2;

    // Press and release of one key.
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    chk("release_disp_en", 32'(disp_en), 32'd0);

    // Typematic repeats.
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();

    // Caps lock toggle and shift hold.
    send(8'h58); send(8'hF0); send(8'h58);
    drain();
    chk("caps_on", 32'(caps_flag), 32'd1);
    send(8'h58); send(8'hF0); send(8'h58);
    drain();
    chk("caps_off", 32'(caps_flag), 32'd0);
    send(8'h12);
    drain();
    chk("shift_on", 32'(shift_flag), 32'd1);
    send(8'hF0); send(8'h12);
    drain();
    chk("shift_off", 32'(shift_flag), 32'd0);

    // Extended key with ready held high: pop strobe on every second cycle.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst_nd%0d", i), 32'(nextdata_n), (i % 2 == 1) ? 32'd0 : 32'd1);
    end
    drain();

    // Overflow while idle drops a pending break prefix and sets err.
    send(8'hF0);
    drain();
    overflow = 1'b1; model_ovf();
    @(posedge clk); #2;
    overflow = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    send(8'h1C);
    drain();

    // Byte captured together with overflow produces no event.
    overflow = 1'b1; model_ovf();
    fifo_q.push_back(8'h2A);
    drain();
    overflow = 1'b0;

    // Press counter wrap.
    n = 0;
    while (m_cnt != 255 && n < 600) begin
      send((n % 2 == 0) ? 8'h1B : 8'h1C);
      n++;
    end
    drain();
    chk("count_ff", 32'(key_count), 32'hFF);
    send(8'h2A);
    drain();
    chk("count_wrap", 32'(key_count), 32'h00);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset in the ACK cycle of a break prefix.
    send(8'hF0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nextdata_n != 1'b0 && n < 50);
    chk("ack_wait_timeout", 32'(n >= 50), 32'd0);
    #1 clrn = 1'b1;
    #1;
    chk("midack_nextdata_n", 32'(nextdata_n), 32'd1);
    chk("midack_clear", 32'({err, caps_flag, disp_en, key_count}), 32'd0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #2;
    clrn = 1'b0;
    send(8'h1C);
    drain();
    chk("after_rst_make", 32'(key_make), 32'd1);

    // Randomised byte stream.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) send(8'($urandom_range(0, 255)));
      else send(pick[$urandom_range(0, 9)]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2;
    end
    drain();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
